// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered read data,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_param #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned AFULL_TH  = 28,
   parameter int unsigned AEMPTY_TH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              clr_err,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   // Storage has no reset so it can map onto RAM.
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              data_valid_q, data_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              full_c, empty_c;
   logic              rd_acc, wr_acc;

   // Status decode from the registered occupancy.
   always_comb begin
      full_c       = (count_q == CNT_W'(DEPTH));
      empty_c      = (count_q == '0);
      almost_full  = (count_q >= CNT_W'(AFULL_TH));
      almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
   end

   // Acceptance: a write on full is allowed only alongside an accepted read; no bypass on empty.
   always_comb begin
      rd_acc = rd_en && !empty_c;
      wr_acc = wr_en && (!full_c || rd_acc);
   end

   // Next-state for pointers, count, read data and error flags.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      overflow_d   = overflow_q && !clr_err;
      underflow_d  = underflow_q && !clr_err;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
         data_out_d   = mem_q[rd_ptr_q];
         data_valid_d = 1'b1;
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A new error event wins over a coincident clear.
      if (wr_en && !wr_acc) begin
         overflow_d = 1'b1;
      end
      if (rd_en && !rd_acc) begin
         underflow_d = 1'b1;
      end
   end

   // Control and read-data registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // Storage write port; gated by reset so nothing lands during a reset cycle.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   always_comb begin
      data_out   = data_out_q;
      data_valid = data_valid_q;
      full       = full_c;
      empty      = empty_c;
      count      = count_q;
      overflow   = overflow_q;
      underflow  = underflow_q;
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_sync_fifo_param;

   localparam int unsigned SD = 4;   // small instance depth
   localparam int unsigned SAF = 3;
   localparam int unsigned SAE = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Small instance: DATA_W=8, ADDR_W=2.
   logic       s_rst, s_wr, s_rd, s_clr;
   logic [7:0] s_din, s_dout;
   logic       s_dv, s_full, s_emp, s_af, s_ae, s_ov, s_un;
   logic [2:0] s_cnt;

   // Default-parameter instance.
   logic        b_rst, b_wr, b_rd, b_clr;
   logic [31:0] b_din, b_dout;
   logic        b_dv, b_full, b_emp, b_af, b_ae, b_ov, b_un;
   logic [5:0]  b_cnt;

   sync_fifo_param #(.DATA_W(8), .ADDR_W(2), .AFULL_TH(3), .AEMPTY_TH(1)) u_small (
      .clk(clk), .rst(s_rst), .data_in(s_din), .wr_en(s_wr), .rd_en(s_rd), .clr_err(s_clr),
      .data_out(s_dout), .data_valid(s_dv), .full(s_full), .empty(s_emp),
      .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
      .overflow(s_ov), .underflow(s_un));

   sync_fifo_param u_big (
      .clk(clk), .rst(b_rst), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd), .clr_err(b_clr),
      .data_out(b_dout), .data_valid(b_dv), .full(b_full), .empty(b_emp),
      .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
      .overflow(b_ov), .underflow(b_un));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       rst, wr, rd, clr;
      logic [7:0] din;
      int         cnt;
      logic       dv;
      logic [7:0] dout;
      logic       ov, un;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic wr, input logic rd, input logic clr,
                      input logic [7:0] din, input int cnt, input logic dv,
                      input logic [7:0] dout, input logic ov, input logic un);
      vec_t v;
      v.rst = rst; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
      v.cnt = cnt; v.dv = dv; v.dout = dout; v.ov = ov; v.un = un;
      vecs.push_back(v);
   endtask

   task automatic s_cycle(input logic rst, input logic wr, input logic rd, input logic clr,
                          input logic [7:0] din);
      @(negedge clk);
      s_rst = rst; s_wr = wr; s_rd = rd; s_clr = clr; s_din = din;
      @(posedge clk);
      #1;
   endtask

   task automatic b_cycle(input logic rst, input logic wr, input logic rd, input logic clr,
                          input logic [31:0] din);
      @(negedge clk);
      b_rst = rst; b_wr = wr; b_rd = rd; b_clr = clr; b_din = din;
      @(posedge clk);
      #1;
   endtask

   task automatic s_check_all(input string tag, input int cnt, input logic dv,
                              input logic [7:0] dout, input logic ov, input logic un);
      chk({tag, ".count"}, 32'(s_cnt), 32'(cnt));
      chk({tag, ".dv"}, 32'(s_dv), 32'(dv));
      chk({tag, ".dout"}, 32'(s_dout), 32'(dout));
      chk({tag, ".ovf"}, 32'(s_ov), 32'(ov));
      chk({tag, ".unf"}, 32'(s_un), 32'(un));
      chk({tag, ".full"}, 32'(s_full), 32'(cnt == int'(SD)));
      chk({tag, ".empty"}, 32'(s_emp), 32'(cnt == 0));
      chk({tag, ".afull"}, 32'(s_af), 32'(cnt >= int'(SAF)));
      chk({tag, ".aempty"}, 32'(s_ae), 32'(cnt <= int'(SAE)));
   endtask

   // Reference model state (randomized phase).
   logic [7:0] mq[$];
   logic [7:0] m_dout;
   logic       m_dv, m_ov, m_un;

   initial begin
      s_rst = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0; s_din = '0;
      b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = '0;

      //   rst wr rd clr din    cnt dv dout  ov un
      // reset then idle
      add(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      add(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      // fill to full, then one rejected write
      add(0, 1, 0, 0, 8'h11, 1, 0, 8'h00, 0, 0);
      add(0, 1, 0, 0, 8'h22, 2, 0, 8'h00, 0, 0);
      add(0, 1, 0, 0, 8'h33, 3, 0, 8'h00, 0, 0);
      add(0, 1, 0, 0, 8'h44, 4, 0, 8'h00, 0, 0);
      add(0, 1, 0, 0, 8'h55, 4, 0, 8'h00, 1, 0);
      // drain, fifth read rejected
      add(0, 0, 1, 0, 8'h00, 3, 1, 8'h11, 1, 0);
      add(0, 0, 1, 0, 8'h00, 2, 1, 8'h22, 1, 0);
      add(0, 0, 1, 0, 8'h00, 1, 1, 8'h33, 1, 0);
      add(0, 0, 1, 0, 8'h00, 0, 1, 8'h44, 1, 0);
      add(0, 0, 1, 0, 8'h00, 0, 0, 8'h44, 1, 1);
      add(0, 0, 0, 1, 8'h00, 0, 0, 8'h44, 0, 0);
      // full with simultaneous read+write, then drain across the wrap
      add(0, 1, 0, 0, 8'hA1, 1, 0, 8'h44, 0, 0);
      add(0, 1, 0, 0, 8'hA2, 2, 0, 8'h44, 0, 0);
      add(0, 1, 0, 0, 8'hA3, 3, 0, 8'h44, 0, 0);
      add(0, 1, 0, 0, 8'hA4, 4, 0, 8'h44, 0, 0);
      add(0, 1, 1, 0, 8'hAA, 4, 1, 8'hA1, 0, 0);
      add(0, 0, 1, 0, 8'h00, 3, 1, 8'hA2, 0, 0);
      add(0, 0, 1, 0, 8'h00, 2, 1, 8'hA3, 0, 0);
      add(0, 0, 1, 0, 8'h00, 1, 1, 8'hA4, 0, 0);
      add(0, 0, 1, 0, 8'h00, 0, 1, 8'hAA, 0, 0);
      // empty with simultaneous read+write: no bypass
      add(0, 1, 1, 0, 8'h5A, 1, 0, 8'hAA, 0, 1);
      add(0, 0, 1, 0, 8'h00, 0, 1, 8'h5A, 0, 1);
      // clear coinciding with a new rejected read: set wins, then plain clear
      add(0, 0, 1, 1, 8'h00, 0, 0, 8'h5A, 0, 1);
      add(0, 0, 0, 1, 8'h00, 0, 0, 8'h5A, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         s_cycle(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
         s_check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dv, vecs[i].dout,
                     vecs[i].ov, vecs[i].un);
      end

      // Default parameters: reset mid-stream discards contents.
      b_cycle(1, 0, 0, 0, 32'h0);
      chk("big.reset_count", 32'(b_cnt), 32'd0);
      chk("big.reset_empty", 32'(b_emp), 32'd1);
      for (int i = 0; i < 20; i++) b_cycle(0, 1, 0, 0, 32'(100 + i));
      chk("big.count20", 32'(b_cnt), 32'd20);
      chk("big.aempty20", 32'(b_ae), 32'd0);
      chk("big.afull20", 32'(b_af), 32'd0);
      b_cycle(1, 0, 0, 0, 32'h0);
      chk("big.rst_mid_count", 32'(b_cnt), 32'd0);
      b_cycle(0, 1, 0, 0, 32'h1);
      chk("big.count1", 32'(b_cnt), 32'd1);
      b_cycle(0, 0, 1, 0, 32'h0);
      chk("big.dout", b_dout, 32'h1);
      chk("big.dv", 32'(b_dv), 32'd1);
      chk("big.count0", 32'(b_cnt), 32'd0);
      b_cycle(0, 0, 1, 0, 32'h0);
      chk("big.unf", 32'(b_un), 32'd1);
      b_cycle(0, 0, 1, 1, 32'h0);
      chk("big.unf_setwins", 32'(b_un), 32'd1);
      b_cycle(0, 0, 0, 1, 32'h0);
      chk("big.unf_clr", 32'(b_un), 32'd0);
      chk("big.dout_hold", b_dout, 32'h1);

      // Randomized traffic on the small instance against a queue model.
      s_cycle(1, 0, 0, 0, 8'h00);
      mq.delete(); m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         logic rs, w, r, c, racc, wacc;
         logic [7:0] d;
         rs = ($urandom_range(99) < 2);
         w  = ($urandom_range(99) < 55);
         r  = ($urandom_range(99) < 50);
         c  = ($urandom_range(99) < 5);
         d  = 8'($urandom);
         s_cycle(rs, w, r, c, d);
         if (rs) begin
            mq.delete(); m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
         end else begin
            racc = r && (mq.size() != 0);
            wacc = w && ((mq.size() != int'(SD)) || racc);
            m_dv = racc;
            if (racc) m_dout = mq.pop_front();
            if (wacc) mq.push_back(d);
            m_ov = (m_ov && !c) || (w && !wacc);
            m_un = (m_un && !c) || (r && !racc);
         end
         s_check_all($sformatf("rnd%0d", n), mq.size(), m_dv, m_dout, m_ov, m_un);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
